// File: rtl/dehaze_if.sv
// Stream interface between the transmission stage, the radiance recovery block and its consumer.
// master drives pixels, inv_t and atmospheric light; slave returns recovered pixels and status.
interface dehaze_if #(
  parameter int AW = 3
) ();
  logic [23:0]   pix_in;
  logic          pix_valid;
  logic [11:0]   inv_t;
  logic          inv_t_valid;
  logic [7:0]    A_r;
  logic [7:0]    A_g;
  logic [7:0]    A_b;
  logic [23:0]   pix_out;
  logic          out_valid;
  logic [AW:0]   fifo_level;
  logic          err_ovf;
  logic          err_udf;

  modport master (
    output pix_in, pix_valid, inv_t, inv_t_valid, A_r, A_g, A_b,
    input  pix_out, out_valid, fifo_level, err_ovf, err_udf
  );

  modport slave (
    input  pix_in, pix_valid, inv_t, inv_t_valid, A_r, A_g, A_b,
    output pix_out, out_valid, fifo_level, err_ovf, err_udf
  );
endinterface

// File: rtl/dehaze_recover.sv
// Scene radiance recovery: buffers pixels until their inv_t arrives, then computes
// J = (I - A) * inv_t + A per channel in a 3-stage pipeline, clamped to 8 bits.
module dehaze_recover #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input logic     clk,
  input logic     rst_n,
  dehaze_if.slave bus
);
  localparam int CW = AW + 1;

  logic [23:0]          mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        cnt_q;
  logic                 err_ovf_q, err_udf_q;
  logic                 full, empty, push, pop;

  logic                 v1_q, v2_q, out_valid_q;
  logic signed [8:0]    d1_q [3];
  logic [11:0]          it1_q;
  logic [7:0]           a1_q [3];
  logic signed [20:0]   p2_q [3];
  logic [7:0]           a2_q [3];
  logic [23:0]          pix_out_q;

  logic [23:0]          rd_pix;
  logic [7:0]           a_in [3];
  logic signed [8:0]    d_d [3];
  logic signed [20:0]   p_d [3];
  logic signed [20:0]   r_d [3];
  logic signed [20:0]   s_d [3];
  logic [23:0]          pix_out_d;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign pop   = bus.inv_t_valid && !empty;
  // A full FIFO still accepts a pixel when the same cycle frees a slot.
  assign push  = bus.pix_valid && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.pix_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (bus.pix_valid && full && !pop) err_ovf_q <= 1'b1;
      if (bus.inv_t_valid && empty)      err_udf_q <= 1'b1;
    end
  end

  // Channel index: 0 = B, 1 = G, 2 = R, matching the RGB888 bit layout.
  always_comb begin
    rd_pix    = mem_q[rd_ptr_q];
    a_in[0]   = bus.A_b;
    a_in[1]   = bus.A_g;
    a_in[2]   = bus.A_r;
    pix_out_d = '0;
    for (int c = 0; c < 3; c++) begin
      d_d[c] = $signed({1'b0, rd_pix[c*8 +: 8]}) - $signed({1'b0, a_in[c]});
      // Operands pre-extended to 21 bits; the product magnitude stays below 2^20.
      p_d[c] = $signed({{12{d1_q[c][8]}}, d1_q[c]}) * $signed({9'b0, it1_q});
      r_d[c] = (p2_q[c] + 21'sd128) >>> 8;
      s_d[c] = r_d[c] + $signed({13'b0, a2_q[c]});
      if (s_d[c] < 0)
        pix_out_d[c*8 +: 8] = 8'd0;
      else if (s_d[c] > 21'sd255)
        pix_out_d[c*8 +: 8] = 8'd255;
      else
        pix_out_d[c*8 +: 8] = s_d[c][7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      it1_q       <= '0;
      pix_out_q   <= '0;
      for (int c = 0; c < 3; c++) begin
        d1_q[c] <= '0;
        a1_q[c] <= '0;
        p2_q[c] <= '0;
        a2_q[c] <= '0;
      end
    end else begin
      v1_q        <= pop;
      v2_q        <= v1_q;
      out_valid_q <= v2_q;
      if (pop) begin
        it1_q <= bus.inv_t;
        for (int c = 0; c < 3; c++) begin
          d1_q[c] <= d_d[c];
          a1_q[c] <= a_in[c];
        end
      end
      if (v1_q) begin
        for (int c = 0; c < 3; c++) begin
          p2_q[c] <= p_d[c];
          a2_q[c] <= a1_q[c];
        end
      end
      if (v2_q) pix_out_q <= pix_out_d;
    end
  end

  assign bus.pix_out    = pix_out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.fifo_level = cnt_q;
  assign bus.err_ovf    = err_ovf_q;
  assign bus.err_udf    = err_udf_q;
endmodule

// File: tb/tb_dehaze_recover.sv
// Scoreboard bench for dehaze_recover: stimulus queues expected pixels and their due cycle,
// a negedge monitor pops and compares on every out_valid.
module tb_dehaze_recover;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dehaze_if #(.AW(3)) bus ();
  dehaze_recover #(.DEPTH(8), .AW(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [23:0] pix;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   mlevel = 0;
  int   max_level = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (int'(bus.fifo_level) > max_level) max_level = int'(bus.fifo_level);
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out_valid: got pix_out=%h with no result expected (t=%0t)", bus.pix_out, $time);
        end else begin
          e = sb.pop_front();
          check("pix_out", {8'h0, bus.pix_out}, {8'h0, e.pix});
          check("latency_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Reference channel math with floor division written out explicitly.
  function automatic logic [7:0] ref_ch(input int i, input int a, input int t);
    int p, r, s;
    p = (i - a) * t + 128;
    r = (p >= 0) ? p / 256 : -((-p + 255) / 256);
    s = r + a;
    if (s < 0) return 8'd0;
    if (s > 255) return 8'd255;
    return 8'(s);
  endfunction

  function automatic logic [23:0] ref_pix(input logic [23:0] px, input logic [11:0] t,
                                          input logic [7:0] ar, input logic [7:0] ag, input logic [7:0] ab);
    return {ref_ch(int'(px[23:16]), int'(ar), int'(t)),
            ref_ch(int'(px[15:8]),  int'(ag), int'(t)),
            ref_ch(int'(px[7:0]),   int'(ab), int'(t))};
  endfunction

  function automatic logic [23:0] stream_pix(input int j);
    return {8'(j * 37 + 5), 8'(j * 91 + 200), 8'(255 - j * 13)};
  endfunction

  function automatic logic [11:0] stream_inv(input int j);
    return 12'(j * 41 + 16);
  endfunction

  // Drive one cycle of inputs; e is the expected result if this cycle pops a pixel.
  task automatic drive(input logic pv, input logic [23:0] p, input logic tv,
                       input logic [11:0] t, input logic [23:0] e);
    logic popm, pushm;
    bus.pix_valid   = pv;
    bus.pix_in      = p;
    bus.inv_t_valid = tv;
    bus.inv_t       = t;
    popm  = tv && (mlevel > 0);
    pushm = pv && ((mlevel < 8) || popm);
    if (popm) sb.push_back(exp_t'{pix: e, cyc: cyc + 3});
    mlevel = mlevel + int'(pushm) - int'(popm);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 24'h0, 1'b0, 12'h0, 24'h0);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb.size() > 0 && k < 50) begin
      idle(1);
      k++;
    end
    check("drain_queue_empty", sb.size(), 0);
  endtask

  task automatic set_a(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    bus.A_r = r;
    bus.A_g = g;
    bus.A_b = b;
  endtask

  logic [23:0] vec_pix [4] = '{24'h646464, 24'hFAC964, 24'hC964FA, 24'h00FFC8};
  logic [11:0] vec_inv [4] = '{12'h200,    12'h180,    12'h180,    12'hFFF};
  logic [23:0] vec_exp [4] = '{24'h000000, 24'hFFCA32, 24'hCA32FF, 24'h00FFC8};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] pp [10];
    bus.pix_valid = 1'b0; bus.pix_in = '0; bus.inv_t_valid = 1'b0; bus.inv_t = '0;
    set_a(8'd0, 8'd0, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_pix_out", bus.pix_out, 0);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_fifo_level", bus.fifo_level, 0);
    check("reset_err_ovf", bus.err_ovf, 0);
    check("reset_err_udf", bus.err_udf, 0);
    rst_n = 1'b1;
    idle(2);

    // Identity
    set_a(8'd200, 8'd200, 8'd200);
    drive(1'b1, 24'h64C8FA, 1'b0, 12'h0, 24'h0);
    idle(5);
    drive(1'b0, 24'h0, 1'b1, 12'h100, 24'h64C8FA);
    wait_drain();

    // Arithmetic, clamp, rounding
    for (int i = 0; i < 4; i++) drive(1'b1, vec_pix[i], 1'b0, 12'h0, 24'h0);
    for (int i = 0; i < 4; i++) drive(1'b0, 24'h0, 1'b1, vec_inv[i], vec_exp[i]);
    wait_drain();
    set_a(8'd50, 8'd100, 8'd150);
    drive(1'b1, 24'h00FF96, 1'b0, 12'h0, 24'h0);
    drive(1'b1, 24'h123456, 1'b1, 12'h0C0, 24'h0DD896);
    drive(1'b0, 24'h0, 1'b1, 12'h000, 24'h326496);
    wait_drain();

    // Streaming
    set_a(8'd60, 8'd120, 8'd180);
    max_level = 0;
    for (int j = 0; j < 106; j++)
      drive(j < 100, stream_pix(j), j >= 6, stream_inv(j - 6),
            ref_pix(stream_pix(j - 6), stream_inv(j - 6), 8'd60, 8'd120, 8'd180));
    wait_drain();
    check("stream_peak_level", max_level, 6);
    check("stream_err_ovf", bus.err_ovf, 0);
    check("stream_err_udf", bus.err_udf, 0);

    // Overflow
    set_a(8'd200, 8'd200, 8'd200);
    for (int k = 0; k < 10; k++) pp[k] = 24'h102030 + 24'(k) * 24'h010101;
    for (int k = 0; k < 8; k++) drive(1'b1, pp[k], 1'b0, 12'h0, 24'h0);
    check("ovf_level_full", bus.fifo_level, 8);
    check("ovf_err_before", bus.err_ovf, 0);
    drive(1'b1, pp[8], 1'b0, 12'h0, 24'h0);
    check("ovf_err_set", bus.err_ovf, 1);
    check("ovf_level_after_drop", bus.fifo_level, 8);
    drive(1'b1, pp[9], 1'b1, 12'h100, pp[0]);
    check("ovf_level_push_pop", bus.fifo_level, 8);
    for (int k = 1; k < 8; k++) drive(1'b0, 24'h0, 1'b1, 12'h100, pp[k]);
    drive(1'b0, 24'h0, 1'b1, 12'h100, pp[9]);
    wait_drain();
    check("ovf_level_drained", bus.fifo_level, 0);

    // Underflow
    check("udf_err_before", bus.err_udf, 0);
    drive(1'b0, 24'h0, 1'b1, 12'h100, 24'h0);
    check("udf_err_set", bus.err_udf, 1);
    check("udf_level_empty", bus.fifo_level, 0);
    drive(1'b1, 24'hA5B6C7, 1'b1, 12'h100, 24'h0);
    check("udf_pixel_kept", bus.fifo_level, 1);
    idle(4);
    drive(1'b0, 24'h0, 1'b1, 12'h100, 24'hA5B6C7);
    wait_drain();

    // Reset mid-stream: 4 buffered, 2 in flight
    for (int k = 0; k < 6; k++) drive(1'b1, pp[k], 1'b0, 12'h0, 24'h0);
    drive(1'b0, 24'h0, 1'b1, 12'h100, pp[0]);
    drive(1'b0, 24'h0, 1'b1, 12'h100, pp[1]);
    check("pre_reset_level", bus.fifo_level, 4);
    rst_n = 1'b0;
    #1;
    sb.delete();
    mlevel = 0;
    check("mid_reset_pix_out", bus.pix_out, 0);
    check("mid_reset_out_valid", bus.out_valid, 0);
    check("mid_reset_level", bus.fifo_level, 0);
    check("mid_reset_err_ovf", bus.err_ovf, 0);
    check("mid_reset_err_udf", bus.err_udf, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(6);
    drive(1'b1, 24'h64C8FA, 1'b0, 12'h0, 24'h0);
    idle(5);
    drive(1'b0, 24'h0, 1'b1, 12'h100, 24'h64C8FA);
    wait_drain();
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dehaze_recover.md
Name: dehaze_recover

Overview:
- Consumer of the transmission stage's `inv_t`/`out_valid` stream.
- Buffers RGB pixels that arrive ahead of their `inv_t`, pairs them in order, and computes the scene radiance per channel: J = (I − A)·inv_t + A, clamped to 8 bits.
- Sits between the transmission calculation and the video output formatter.

Parameters:
- DEPTH, 8, pixel FIFO entries; power of two, ≥ 8; the upstream `inv_t` latency is 6 cycles.
- AW, 3, FIFO address width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pix_in  in  24  RGB888 {R[23:16],G[15:8],B[7:0]}; sampled when pix_valid=1.
- pix_valid  in  1  push pix_in into FIFO.
- inv_t  in  12  1/t, unsigned Q4.8 (0x100 = 1.0).
- inv_t_valid  in  1  inv_t qualifier; pops one pixel.
- A_r, A_g, A_b  in  8 each  atmospheric light; static during a frame, sampled at stage 1.
- pix_out  out  24  recovered RGB888.
- out_valid  out  1  pix_out qualifier, one-cycle pulse per result.
- fifo_level  out  AW+1  current FIFO occupancy, 0..DEPTH.
- err_ovf  out  1  sticky: push attempted while full with no pop.
- err_udf  out  1  sticky: inv_t_valid while FIFO empty.

Behaviour:
- Reset (async, rst_n=0):
  - pix_out=0, out_valid=0, fifo_level=0, err_ovf=0, err_udf=0.
  - FIFO pointers and all pipeline valids cleared.
  - Reset mid-operation discards all buffered pixels and in-flight results; no out_valid after release until new pairs arrive.
- FIFO:
  - Synchronous write/read pointers, AW bits each plus a separate count register.
  - Pointers wrap modulo DEPTH.
  - Push when pix_valid and (not full, or pop in the same cycle).
  - Pop when inv_t_valid and not empty.
  - Full with simultaneous push and pop: both occur, level unchanged, no error.
  - Full with push only: pixel dropped, err_ovf←1.
  - Empty with inv_t_valid: inv_t discarded, err_udf←1, no output generated. This holds even if pix_valid=1 that same cycle; the pushed pixel is stored and waits for the next inv_t.
  - Error flags clear only on reset.
- Pipeline (per channel c∈{R,G,B}; one result per cycle; no back-pressure):
  - S1, pop cycle+1:
    - Register the popped pixel I_c, inv_t, and A_c.
    - d_c = I_c − A_c, signed 9 bit, range −255..255.
  - S2:
    - p_c = d_c × inv_t, with inv_t zero-extended to signed 13 bit.
    - p_c is a 21-bit signed result; |p| ≤ 1,044,225, so no overflow.
  - S3:
    - r_c = (p_c + 128) >>> 8, arithmetic shift: round half up toward +∞ on the Q.8 boundary.
    - s_c = r_c + A_c, signed 14 bit.
    - pix_out_c = 0 if s_c<0; 255 if s_c>255; else s_c[7:0].
  - Timing:
    - out_valid asserts exactly 3 cycles after the inv_t_valid cycle that popped the pixel.
    - Latency from pop to out_valid is fixed at 3.
  - pix_out holds its last value while out_valid=0.
- Ordering: results leave in strict FIFO order; the k-th accepted inv_t pairs with the k-th accepted pixel.
- inv_t=0 is legal: output equals A_c. No divide occurs in this block.

Test Plan:
- Identity: A=(200,200,200), pix_in=0x64C8FA, then inv_t=0x100 after 6 cycles → pix_out=0x64C8FA; out_valid exactly 3 cycles after inv_t_valid.
- Arithmetic, clamp, rounding:
  - A=200, I=100, inv_t=0x200 → 0 (−200+200).
  - I=250, inv_t=0x180 → 275, clamped to 255.
  - I=201, inv_t=0x180 → 202 (rounding); check all three channels independently.
- Streaming: 100 back-to-back pixels with pix_valid every cycle, each inv_t arriving 6 cycles later → 100 in-order outputs; fifo_level peaks at 6; err_ovf=err_udf=0.
- Overflow:
  - Push 8 pixels with no inv_t → fifo_level=8.
  - A 9th push → dropped, err_ovf=1.
  - Push and pop in the same cycle while full → level stays 8, no new error.
  - Drain 8 → the first 8 pixels are output in order.
- Underflow: inv_t_valid with FIFO empty (with and without a simultaneous pix_valid) → no out_valid, err_udf=1; the simultaneous pixel remains, fifo_level=1.
- Reset mid-stream: assert rst_n=0 with 4 pixels buffered and 2 results in flight → all outputs 0 immediately (async); after release, no spurious out_valid, and a new pair is processed correctly.
